// File: rtl/dmem_arbiter.sv
// Arbitrates the single data-memory port between instruction fetch and load/store.
// Optional DMEM_ARB_RR_EN selects round-robin arbitration instead of fixed LS > IF priority.
module dmem_arbiter #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req_valid,
    output logic            if_req_ready,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_rsp_valid,
    output logic [XLEN-1:0] if_rsp_data,
    input  logic            ls_req_valid,
    output logic            ls_req_ready,
    input  logic            ls_wen,
    input  logic [XLEN-1:0] ls_addr,
    input  logic [XLEN-1:0] ls_wdata,
    input  logic [7:0]      ls_wmask,
    output logic            ls_rsp_valid,
    output logic [XLEN-1:0] ls_rsp_data,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic            mem_wen,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [7:0]      mem_wmask,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic            busy,
    output logic            timeout_err
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StWait = 2'd2;
    localparam logic [1:0] StResp = 2'd3;

    logic [1:0]      state;
    logic            owner;  // 0 = IF, 1 = LS
    logic [CntW-1:0] wait_cnt;
    logic [XLEN-1:0] rsp_data;
    logic            ls_win;
    logic            accept;

`ifdef DMEM_ARB_RR_EN
    logic            last_owner;
    // On conflict the side that did not complete the previous transaction wins.
    assign ls_win = ls_req_valid & (~if_req_valid | ~last_owner);
`else
    assign ls_win = ls_req_valid;
`endif

    assign ls_req_ready = (state == StIdle) & ls_win;
    assign if_req_ready = (state == StIdle) & if_req_valid & ~ls_win;
    assign accept       = if_req_ready | ls_req_ready;
    assign busy         = (state != StIdle);
    assign if_rsp_data  = rsp_data;
    assign ls_rsp_data  = rsp_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= StIdle;
            owner         <= 1'b0;
            wait_cnt      <= '0;
            rsp_data      <= '0;
            if_rsp_valid  <= 1'b0;
            ls_rsp_valid  <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_wen       <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
            timeout_err   <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            last_owner    <= 1'b0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    if (accept) begin
                        owner         <= ls_win;
                        mem_wen       <= ls_win & ls_wen;
                        mem_addr      <= ls_win ? ls_addr : if_addr;
                        mem_wdata     <= ls_win ? ls_wdata : '0;
                        mem_wmask     <= ls_win ? ls_wmask : 8'h00;
                        mem_req_valid <= 1'b1;
                        state         <= StReq;
                    end
                end
                StReq: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        wait_cnt      <= '0;
                        state         <= StWait;
                    end
                end
                StWait: begin
                    if (wait_cnt != CntW'(TIMEOUT)) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                    // A response in the final allowed cycle still wins over the timeout.
                    if (mem_rsp_valid) begin
                        rsp_data     <= mem_wen ? '0 : mem_rsp_data;
                        if_rsp_valid <= ~owner;
                        ls_rsp_valid <= owner;
                        state        <= StResp;
                    end else if (wait_cnt >= CntW'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= StIdle;
                    end
                end
                StResp: begin
                    if_rsp_valid <= 1'b0;
                    ls_rsp_valid <= 1'b0;
`ifdef DMEM_ARB_RR_EN
                    last_owner   <= owner;
`endif
                    state        <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter against a transaction-level model.
module tb_dmem_arbiter;

    localparam int unsigned XLEN = 64;
    localparam int unsigned TO   = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            if_req_valid, if_req_ready, if_rsp_valid;
    logic [XLEN-1:0] if_addr, if_rsp_data;
    logic            ls_req_valid, ls_req_ready, ls_wen, ls_rsp_valid;
    logic [XLEN-1:0] ls_addr, ls_wdata, ls_rsp_data;
    logic [7:0]      ls_wmask, mem_wmask;
    logic            mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
    logic [XLEN-1:0] mem_addr, mem_wdata, mem_rsp_data;
    logic            busy, timeout_err;

    always #5 clk = ~clk;

    dmem_arbiter #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_wen(ls_wen),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .busy(busy), .timeout_err(timeout_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Requester-side model state: pending requests and who completed last.
    bit              if_pend, ls_pend, last_ls_m;
    logic [XLEN-1:0] if_a, ls_a, ls_wd;
    bit              ls_w;
    logic [7:0]      ls_m;
    bit              grants[4];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mem_data(input logic [63:0] a);
        return (a * 64'h9E3779B97F4A7C15) ^ 64'h0123456789ABCDEF;
    endfunction

    function automatic bit pick_ls(input bit ifv, input bit lsv);
        if (!ifv) return 1'b1;
        if (!lsv) return 1'b0;
`ifdef DMEM_ARB_RR_EN
        return !last_ls_m;
`else
        return 1'b1;
`endif
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive();
        if_req_valid = if_pend;
        if_addr      = if_a;
        ls_req_valid = ls_pend;
        ls_addr      = ls_a;
        ls_wen       = ls_w;
        ls_wdata     = ls_wd;
        ls_wmask     = ls_m;
    endtask

    task automatic new_if();
        if_pend = 1'b1;
        if_a    = {$urandom(), $urandom()};
    endtask

    task automatic new_ls();
        ls_pend = 1'b1;
        ls_a    = {$urandom(), $urandom()} & ~64'h7;
        ls_w    = 1'($urandom_range(0, 1));
        ls_wd   = {$urandom(), $urandom()};
        ls_m    = 8'($urandom());
    endtask

    // One full transaction starting in IDLE; leaves the bench positioned in the next IDLE cycle.
    task automatic run_txn(input int stall, input int lat, input bit spur,
                           input bit use_fix, input logic [63:0] fix, output bit win_ls);
        logic [63:0] e_addr, e_wdata, rdata;
        logic [7:0]  e_mask;
        bit          e_wen;
        drive();
        mem_req_ready = 1'b0;
        mem_rsp_valid = spur;
        mem_rsp_data  = {$urandom(), $urandom()};
        #1;
        win_ls  = pick_ls(if_pend, ls_pend);
        e_addr  = win_ls ? ls_a : if_a;
        e_wen   = win_ls & ls_w;
        e_wdata = ls_wd;
        e_mask  = win_ls ? ls_m : 8'h00;
        rdata   = use_fix ? fix : mem_data(e_addr);
        check_eq("idle_busy", 64'(busy), 64'd0);
        check_eq("idle_if_rsp", 64'(if_rsp_valid), 64'd0);
        check_eq("idle_ls_rsp", 64'(ls_rsp_valid), 64'd0);
        check_eq("if_ready", 64'(if_req_ready), 64'(!win_ls));
        check_eq("ls_ready", 64'(ls_req_ready), 64'(win_ls));
        next_cycle();
        if (win_ls) ls_pend = 1'b0;
        else if_pend = 1'b0;
        drive();
        for (int s = 0; s <= stall; s++) begin
            mem_req_ready = (s == stall);
            mem_rsp_valid = spur;
            #1;
            check_eq("req_valid", 64'(mem_req_valid), 64'd1);
            check_eq("req_addr", mem_addr, e_addr);
            check_eq("req_wen", 64'(mem_wen), 64'(e_wen));
            check_eq("req_wmask", 64'(mem_wmask), 64'(e_mask));
            if (win_ls) check_eq("req_wdata", mem_wdata, e_wdata);
            check_eq("req_busy", 64'(busy), 64'd1);
            check_eq("req_no_ready", 64'({if_req_ready, ls_req_ready}), 64'd0);
            next_cycle();
        end
        mem_req_ready = 1'b0;
        for (int w = 1; w <= lat; w++) begin
            mem_rsp_valid = (w == lat);
            mem_rsp_data  = rdata;
            #1;
            check_eq("wait_req_valid", 64'(mem_req_valid), 64'd0);
            check_eq("wait_rsp", 64'({if_rsp_valid, ls_rsp_valid}), 64'd0);
            check_eq("wait_busy", 64'(busy), 64'd1);
            next_cycle();
        end
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = {$urandom(), $urandom()};
        #1;
        check_eq("rsp_if_valid", 64'(if_rsp_valid), 64'(!win_ls));
        check_eq("rsp_ls_valid", 64'(ls_rsp_valid), 64'(win_ls));
        if (win_ls) check_eq("rsp_ls_data", ls_rsp_data, e_wen ? 64'd0 : rdata);
        else check_eq("rsp_if_data", if_rsp_data, rdata);
        check_eq("rsp_busy", 64'(busy), 64'd1);
        last_ls_m = win_ls;
        next_cycle();
    endtask

    bit w;

    initial begin
        rst = 1'b1;
        if_pend = 0; ls_pend = 0; last_ls_m = 0;
        if_a = '0; ls_a = '0; ls_w = 0; ls_wd = '0; ls_m = '0;
        drive();
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_valids", 64'({if_rsp_valid, ls_rsp_valid, mem_req_valid}), 64'd0);
        check_eq("rst_readies", 64'({if_req_ready, ls_req_ready}), 64'd0);
        check_eq("rst_mem_addr", mem_addr, 64'd0);
        check_eq("rst_mem_wdata", mem_wdata, 64'd0);
        check_eq("rst_mem_wmask", 64'({mem_wen, mem_wmask}), 64'd0);
        check_eq("rst_rsp_data", ls_rsp_data | if_rsp_data, 64'd0);
        check_eq("rst_timeout", 64'(timeout_err), 64'd0);

        // Single load with the minimum round trip.
        ls_pend = 1; ls_a = 64'h80000008; ls_w = 0; ls_wd = '0; ls_m = '0;
        run_txn(0, 1, 0, 1, 64'h1122334455667788, w);

        // Store held through three stalled cycles.
        ls_pend = 1; ls_a = 64'h80000010; ls_w = 1; ls_wd = 64'hAB; ls_m = 8'h01;
        run_txn(3, 2, 0, 0, '0, w);

        // Spurious responses in IDLE and REQ.
        new_if();
        run_txn(1, 2, 1, 0, '0, w);

        // Contention with both sides continuously requesting.
        new_if();
        new_ls();
        for (int k = 0; k < 4; k++) begin
            run_txn($urandom_range(0, 1), $urandom_range(1, 3), 0, 0, '0, w);
            grants[k] = w;
            if (w) new_ls();
            else new_if();
        end
        for (int k = 0; k < 4; k++) begin
`ifdef DMEM_ARB_RR_EN
            check_eq("contention_grant", 64'(grants[k]), 64'((k % 2) == 0));
`else
            check_eq("contention_grant", 64'(grants[k]), 64'd1);
`endif
        end
        // Drain whichever requester is still pending.
        while (if_pend || ls_pend) run_txn(0, 1, 0, 0, '0, w);

        // Timeout: IF fetch with no response.
        new_if();
        drive();
        #1;
        check_eq("to_if_ready", 64'(if_req_ready), 64'd1);
        next_cycle();
        if_pend = 0;
        drive();
        mem_req_ready = 1;
        next_cycle();
        mem_req_ready = 0;
        for (int c = 1; c <= int'(TO); c++) begin
            #1;
            check_eq("to_wait_busy", 64'(busy), 64'd1);
            check_eq("to_wait_err", 64'(timeout_err), 64'd0);
            next_cycle();
        end
        #1;
        check_eq("to_idle_busy", 64'(busy), 64'd0);
        check_eq("to_err_set", 64'(timeout_err), 64'd1);
        check_eq("to_no_rsp", 64'({if_rsp_valid, ls_rsp_valid}), 64'd0);

        // Randomized traffic; the error flag must stay sticky throughout.
        for (int n = 0; n < 150; n++) begin
            if (!if_pend && $urandom_range(0, 1) == 1) new_if();
            if (!ls_pend && $urandom_range(0, 1) == 1) new_ls();
            if (!if_pend && !ls_pend) begin
                if ($urandom_range(0, 1) == 1) new_ls();
                else new_if();
            end
            run_txn($urandom_range(0, 2), $urandom_range(1, 3), 1'($urandom_range(0, 1)),
                    0, '0, w);
        end
        #1;
        check_eq("err_sticky", 64'(timeout_err), 64'd1);
        while (if_pend || ls_pend) run_txn(0, 1, 0, 0, '0, w);

        // Reset in WAIT with a late response.
        new_if();
        drive();
        next_cycle();
        if_pend = 0;
        drive();
        mem_req_ready = 1;
        next_cycle();
        mem_req_ready = 0;
        rst = 1;
        next_cycle();
        rst = 0;
        mem_rsp_valid = 1;
        mem_rsp_data = {$urandom(), $urandom()};
        #1;
        check_eq("rw_busy", 64'(busy), 64'd0);
        check_eq("rw_valids", 64'({if_rsp_valid, ls_rsp_valid, mem_req_valid}), 64'd0);
        check_eq("rw_mem_addr", mem_addr, 64'd0);
        check_eq("rw_rsp_data", if_rsp_data, 64'd0);
        check_eq("rw_err_clear", 64'(timeout_err), 64'd0);
        next_cycle();
        mem_rsp_valid = 0;
        #1;
        check_eq("rw_late_rsp", 64'({if_rsp_valid, ls_rsp_valid}), 64'd0);
        check_eq("rw_idle", 64'(busy), 64'd0);
        last_ls_m = 0;
        new_if();
        run_txn(0, 1, 0, 0, '0, w);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
